// File: rtl/svm_pkg.sv
// Shared types and constants for the SVM coefficient reader: FSM state
// encoding and the ceil-log2 helper used to size the ROM address.
package svm_pkg;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_RUN   = 2'd1,
      ST_DRAIN = 2'd2
   } svm_state_e;

   // Never returns less than 1 so a single-word ROM still gets an address bit.
   function automatic int svm_clog2(input int value);
      int result;
      result = 0;
      while ((1 << result) < value) begin
         result = result + 1;
      end
      if (result < 1) begin
         result = 1;
      end
      return result;
   endfunction

endpackage

// File: rtl/svm_stream_fifo.sv
// Two-entry first-word-fall-through FIFO; the head is forced to zero when
// empty so downstream never sees stale data.
module svm_stream_fifo #(
   parameter int WIDTH = 8
) (
   input  logic             clk_i,
   input  logic             rst_i,
   input  logic             push_i,
   input  logic [WIDTH-1:0] push_data_i,
   input  logic             pop_i,
   output logic             full_o,
   output logic             empty_o,
   output logic [WIDTH-1:0] head_o
);

   logic [WIDTH-1:0] mem_q [2];
   logic             wr_ptr_q;
   logic             rd_ptr_q;
   logic [1:0]       count_q;
   logic [1:0]       count_d;
   logic             do_push;
   logic             do_pop;

   assign empty_o = (count_q == 2'd0);
   assign full_o  = (count_q == 2'd2);
   assign do_push = push_i & ~full_o;
   assign do_pop  = pop_i & ~empty_o;

   always_comb begin
      count_d = count_q;
      case ({do_push, do_pop})
         2'b10:   count_d = count_q + 2'd1;
         2'b01:   count_d = count_q - 2'd1;
         default: count_d = count_q;
      endcase
   end

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         wr_ptr_q <= 1'b0;
         rd_ptr_q <= 1'b0;
         count_q  <= 2'd0;
      end else begin
         if (do_push) begin
            wr_ptr_q <= ~wr_ptr_q;
         end
         if (do_pop) begin
            rd_ptr_q <= ~rd_ptr_q;
         end
         count_q <= count_d;
      end
   end

   // Storage is data only; validity comes entirely from count_q.
   always_ff @(posedge clk_i) begin
      if (do_push) begin
         mem_q[wr_ptr_q] <= push_data_i;
      end
   end

   assign head_o = empty_o ? '0 : mem_q[rd_ptr_q];

endmodule

// File: rtl/svm_coef_reader.sv
// Streams MEM_DEPTH words from an external 1-cycle-latency ROM into a
// ready/valid sink, flagging the final word with out_last.
module svm_coef_reader
   import svm_pkg::*;
#(
   parameter int  BLOCK_LENGTH = 8,
   parameter int  MEM_DEPTH    = 676,
   localparam int ADDR_W       = svm_clog2(MEM_DEPTH)
) (
   input  logic                    clock,
   input  logic                    reset,
   input  logic                    start,
   output logic                    busy,
   output logic                    done,
   output logic [ADDR_W-1:0]       rom_address,
   input  logic [BLOCK_LENGTH-1:0] rom_data,
   output logic [BLOCK_LENGTH-1:0] out_data,
   output logic                    out_valid,
   input  logic                    out_ready,
   output logic                    out_last
);

   localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(MEM_DEPTH - 1);

   svm_state_e          state_q;
   svm_state_e          state_d;
   logic [ADDR_W-1:0]   addr_q;
   logic [ADDR_W-1:0]   addr_d;
   logic                infl_q;
   logic                infl_last_q;
   logic                infl_last_d;
   logic                done_q;
   logic                done_d;
   logic                issue;
   logic                pop;
   logic                fifo_full;
   logic                fifo_empty;
   logic [1:0]          occupancy;
   logic [2:0]          pending;
   logic [BLOCK_LENGTH:0] head;

   assign occupancy = fifo_full ? 2'd2 : (fifo_empty ? 2'd0 : 2'd1);
   assign pending   = {1'b0, occupancy} + {2'b00, infl_q};
   assign pop       = out_valid & out_ready;

   // A read may only be issued if, counting the word still on its way and
   // crediting this cycle's transfer, the FIFO keeps a free slot for it.
   always_comb begin
      state_d     = state_q;
      addr_d      = addr_q;
      done_d      = 1'b0;
      issue       = 1'b0;
      infl_last_d = 1'b0;
      unique case (state_q)
         ST_IDLE: begin
            if (start && !done_q) begin
               state_d = ST_RUN;
               addr_d  = '0;
            end
         end
         ST_RUN: begin
            if (pending < (3'd2 + {2'b00, pop})) begin
               issue       = 1'b1;
               infl_last_d = (addr_q == LAST_ADDR);
               if (addr_q == LAST_ADDR) begin
                  state_d = ST_DRAIN;
               end else begin
                  addr_d = addr_q + 1'b1;
               end
            end
         end
         ST_DRAIN: begin
            if (pop && head[BLOCK_LENGTH]) begin
               state_d = ST_IDLE;
               done_d  = 1'b1;
            end
         end
         default: state_d = ST_IDLE;
      endcase
   end

   always_ff @(posedge clock) begin
      if (reset) begin
         state_q <= ST_IDLE;
         addr_q  <= '0;
         infl_q  <= 1'b0;
         done_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         addr_q  <= addr_d;
         infl_q  <= issue;
         done_q  <= done_d;
      end
   end

   always_ff @(posedge clock) begin
      infl_last_q <= infl_last_d;
   end

   svm_stream_fifo #(
      .WIDTH(BLOCK_LENGTH + 1)
   ) u_fifo (
      .clk_i       (clock),
      .rst_i       (reset),
      .push_i      (infl_q),
      .push_data_i ({infl_last_q, rom_data}),
      .pop_i       (pop),
      .full_o      (fifo_full),
      .empty_o     (fifo_empty),
      .head_o      (head)
   );

   assign busy        = (state_q != ST_IDLE);
   assign done        = done_q;
   assign rom_address = addr_q;
   assign out_valid   = ~fifo_empty;
   assign out_data    = head[BLOCK_LENGTH-1:0];
   assign out_last    = head[BLOCK_LENGTH];

endmodule

// File: tb/tb_svm_coef_reader.sv
// Directed bench for svm_coef_reader: a 4-word ROM instance checked every
// cycle against a transaction-level model, plus a 1-word instance.
module tb_svm_coef_reader;

   logic clock = 1'b0;
   always #5 clock = ~clock;

   logic       reset;
   logic       start;
   logic       out_ready;
   logic       busy;
   logic       done;
   logic       out_valid;
   logic       out_last;
   logic [1:0] rom_address;
   logic [7:0] rom_data = 8'h00;
   logic [7:0] out_data;

   logic       start1;
   logic       out_ready1;
   logic       busy1;
   logic       done1;
   logic       out_valid1;
   logic       out_last1;
   logic [0:0] rom_address1;
   logic [7:0] rom_data1 = 8'h00;
   logic [7:0] out_data1;

   logic [7:0] rom [4] = '{8'h11, 8'h22, 8'h33, 8'h44};

   int n_checks = 0;
   int n_fail   = 0;
   int xfers    = 0;
   int dones    = 0;

   svm_coef_reader #(.BLOCK_LENGTH(8), .MEM_DEPTH(4)) dut (
      .clock(clock), .reset(reset), .start(start), .busy(busy), .done(done),
      .rom_address(rom_address), .rom_data(rom_data), .out_data(out_data),
      .out_valid(out_valid), .out_ready(out_ready), .out_last(out_last)
   );

   svm_coef_reader #(.BLOCK_LENGTH(8), .MEM_DEPTH(1)) dut1 (
      .clock(clock), .reset(reset), .start(start1), .busy(busy1), .done(done1),
      .rom_address(rom_address1), .rom_data(rom_data1), .out_data(out_data1),
      .out_valid(out_valid1), .out_ready(out_ready1), .out_last(out_last1)
   );

   // Synchronous ROMs with one cycle of read latency.
   always @(posedge clock) rom_data <= rom[rom_address];
   always @(posedge clock) rom_data1 <= (rom_address1 == 1'b0) ? 8'hA5 : 8'h00;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   task automatic step(input int n);
      repeat (n) begin
         @(posedge clock);
         #1;
      end
   endtask

   // Transaction-level model: a run begins on an accepted start, words leave
   // in address order, the run ends on the transfer of word 3 and done
   // follows one cycle later.
   bit         seen      = 1'b0;
   bit         m_active  = 1'b0;
   bit         m_done    = 1'b0;
   bit         rst_chk   = 1'b0;
   bit         addr0_chk = 1'b0;
   bit         hold      = 1'b0;
   int         m_idx     = 0;
   logic [7:0] h_data;
   logic       h_last;

   always @(negedge clock) begin
      bit cur_active;
      bit cur_done;
      bit xfer;
      if (seen) begin
         chk("busy", 32'(busy), 32'(m_active));
         chk("done", 32'(done), 32'(m_done));
         if (rst_chk) begin
            chk("rst_valid", 32'(out_valid), 32'd0);
            chk("rst_last", 32'(out_last), 32'd0);
            chk("rst_data", 32'(out_data), 32'd0);
            chk("rst_addr", 32'(rom_address), 32'd0);
         end
         if (addr0_chk) chk("first_addr", 32'(rom_address), 32'd0);
         if (!m_active) chk("idle_valid", 32'(out_valid), 32'd0);
         if (hold) begin
            chk("hold_valid", 32'(out_valid), 32'd1);
            chk("hold_data", 32'(out_data), 32'(h_data));
            chk("hold_last", 32'(out_last), 32'(h_last));
         end
         if (out_valid === 1'b1) begin
            chk("stream_data", 32'(out_data), 32'(rom[m_idx]));
            chk("stream_last", 32'(out_last), 32'(m_idx == 3));
         end
         if (done === 1'b1) dones++;
      end
      cur_active = m_active;
      cur_done   = m_done;
      xfer       = seen && (out_valid === 1'b1) && (out_ready === 1'b1);
      hold       = seen && (out_valid === 1'b1) && (out_ready === 1'b0);
      h_data     = out_data;
      h_last     = out_last;
      m_done     = 1'b0;
      rst_chk    = 1'b0;
      addr0_chk  = 1'b0;
      if (reset) begin
         m_active = 1'b0;
         m_idx    = 0;
         rst_chk  = 1'b1;
         hold     = 1'b0;
         seen     = 1'b1;
      end else begin
         if (xfer) begin
            xfers++;
            if (m_idx == 3) begin
               m_active = 1'b0;
               m_done   = 1'b1;
               m_idx    = 0;
            end else begin
               m_idx++;
            end
         end
         if (!cur_active && start && !cur_done) begin
            m_active  = 1'b1;
            addr0_chk = 1'b1;
         end
      end
   end

   task automatic wait_done(input string name, input int limit);
      int n;
      n = 0;
      while (done !== 1'b1 && n < limit) begin
         step(1);
         n++;
      end
      chk(name, 32'(done), 32'd1);
   endtask

   initial begin
      #200000;
      $display("FAIL global_timeout: simulation did not end");
      $fatal(1, "timeout");
   end

   initial begin
      logic [7:0] lit [4];
      logic [1:0] held_addr;
      int x0;
      int d0;
      lit = '{8'h11, 8'h22, 8'h33, 8'h44};
      reset = 1'b1; start = 1'b0; out_ready = 1'b1;
      start1 = 1'b0; out_ready1 = 1'b1;
      step(2);
      reset = 1'b0;
      step(1);

      // Scenario 1: free-flowing sink, then a start in the done cycle.
      start = 1'b1; step(1); start = 1'b0;
      chk("s1_addr_c1", 32'(rom_address), 32'd0);
      chk("s1_busy_c1", 32'(busy), 32'd1);
      step(1);
      chk("s1_novalid_c2", 32'(out_valid), 32'd0);
      step(1);
      for (int k = 0; k < 4; k++) begin
         chk("s1_valid", 32'(out_valid), 32'd1);
         chk("s1_word", 32'(out_data), 32'(lit[k]));
         chk("s1_last", 32'(out_last), 32'(k == 3));
         step(1);
      end
      chk("s1_done_c7", 32'(done), 32'd1);
      chk("s1_busy_c7", 32'(busy), 32'd0);
      start = 1'b1; step(1); start = 1'b0;
      chk("s1_start_in_done_ignored", 32'(busy), 32'd0);
      chk("s1_done_single", 32'(done), 32'd0);
      step(2);

      // Scenario 2: sink stalls in cycles 3-8.
      x0 = xfers;
      start = 1'b1; step(1); start = 1'b0;
      step(2);
      out_ready = 1'b0;
      held_addr = rom_address;
      for (int c = 3; c <= 8; c++) begin
         chk("s2_hold_word", 32'(out_data), 32'h11);
         chk("s2_hold_addr", 32'(rom_address), 32'(held_addr));
         step(1);
      end
      out_ready = 1'b1;
      wait_done("s2_done", 20);
      step(2);
      chk("s2_xfers", 32'(xfers - x0), 32'd4);

      // Scenario 3: sink ready toggles every cycle.
      x0 = xfers;
      d0 = dones;
      start = 1'b1;
      for (int c = 0; c < 40; c++) begin
         out_ready = (c % 2 == 0);
         if (c == 1) start = 1'b0;
         step(1);
         if (done === 1'b1) break;
      end
      out_ready = 1'b1;
      step(3);
      chk("s3_xfers", 32'(xfers - x0), 32'd4);
      chk("s3_dones", 32'(dones - d0), 32'd1);

      // Scenario 4: starts during the run and on the last transfer are ignored.
      start = 1'b1; step(1); start = 1'b0;
      step(1);
      start = 1'b1; step(1); start = 1'b0;
      step(3);
      start = 1'b1; step(1); start = 1'b0;
      chk("s4_done_c7", 32'(done), 32'd1);
      step(1);
      start = 1'b1; step(1); start = 1'b0;
      chk("s4_addr_c9", 32'(rom_address), 32'd0);
      chk("s4_busy_c9", 32'(busy), 32'd1);
      wait_done("s4_done2", 20);
      step(2);

      // Scenario 5: reset in cycle 4 aborts the run.
      d0 = dones;
      start = 1'b1; step(1); start = 1'b0;
      step(3);
      reset = 1'b1; step(1); reset = 1'b0;
      chk("s5_valid_c5", 32'(out_valid), 32'd0);
      chk("s5_busy_c5", 32'(busy), 32'd0);
      chk("s5_data_c5", 32'(out_data), 32'd0);
      step(6);
      chk("s5_no_done", 32'(dones - d0), 32'd0);
      start = 1'b1; step(1); start = 1'b0;
      step(2);
      chk("s5_first_word", 32'(out_data), 32'h11);
      chk("s5_first_valid", 32'(out_valid), 32'd1);
      wait_done("s5_done", 20);
      step(2);

      // Scenario 6: single-word ROM.
      start1 = 1'b1; step(1); start1 = 1'b0;
      chk("s6_busy_c1", 32'(busy1), 32'd1);
      chk("s6_addr_c1", 32'(rom_address1), 32'd0);
      step(1);
      chk("s6_novalid_c2", 32'(out_valid1), 32'd0);
      step(1);
      chk("s6_valid_c3", 32'(out_valid1), 32'd1);
      chk("s6_word_c3", 32'(out_data1), 32'hA5);
      chk("s6_last_c3", 32'(out_last1), 32'd1);
      step(1);
      chk("s6_done_c4", 32'(done1), 32'd1);
      chk("s6_busy_c4", 32'(busy1), 32'd0);
      chk("s6_valid_c4", 32'(out_valid1), 32'd0);
      step(1);
      chk("s6_done_c5", 32'(done1), 32'd0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
